// File: rtl/atm_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : atm_control_fsm
// Brief    : Button conditioning (sync, debounce, edge) and ATM session FSM
//            driving the 4-bit state code, coin select, amount and withdraw.
// Revision : 1.0 - initial release
// ============================================================================
module atm_control_fsm #(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [15:0] PIN_CODE        = 16'h1234,
    parameter int          MAX_TRIES       = 3,
    parameter int          MSG_CYCLES      = 200000000,
    parameter int          PROC_CYCLES     = 100000000,
    parameter int          TIMEOUT_CYCLES  = 1000000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        BTNU,
    input  logic        BTND,
    input  logic        BTNL,
    input  logic        BTNR,
    input  logic        BTNC,
    input  logic [15:0] SW,
    input  logic [15:0] balance_in,
    output logic [3:0]  state,
    output logic [1:0]  coin_sel,
    output logic [15:0] amount,
    output logic        withdraw_strobe
);

    localparam int c_DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_DWELL_MAX = (MSG_CYCLES > PROC_CYCLES) ? MSG_CYCLES : PROC_CYCLES;
    localparam int c_DWELL_W   = $clog2(c_DWELL_MAX + 1);
    localparam int c_IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_ATT_W     = $clog2(MAX_TRIES + 1);

    localparam logic [c_DEB_W-1:0]   c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DWELL_W-1:0] c_MSG_LAST  = c_DWELL_W'(MSG_CYCLES - 1);
    localparam logic [c_DWELL_W-1:0] c_PROC_LAST = c_DWELL_W'(PROC_CYCLES - 1);
    localparam logic [c_IDLE_W-1:0]  c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_ATT_W-1:0]   c_MAX_ATT   = c_ATT_W'(MAX_TRIES);

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0000,
        S_CARD     = 4'b0001,
        S_PIN      = 4'b0010,
        S_MENU     = 4'b0011,
        S_VIEW_BTC = 4'b0100,
        S_VIEW_ETH = 4'b0101,
        S_VIEW_XRP = 4'b0110,
        S_VIEW_LTC = 4'b0111,
        S_AMOUNT   = 4'b1000,
        S_CONFIRM  = 4'b1001,
        S_PROCESS  = 4'b1010,
        S_SUCCESS  = 4'b1011,
        S_INVALID  = 4'b1100,
        S_LOCKED   = 4'b1101,
        S_GOODBYE  = 4'b1110
    } state_t;

    // Button vector ordered so that a higher index means higher priority.
    logic [4:0] w_raw;
    logic [4:0] w_pulse;

    assign w_raw = {BTNU, BTNC, BTND, BTNL, BTNR};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_level;
        logic               r_level_d;
        logic [c_DEB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_level_d <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync1   <= w_raw[i];
                r_sync2   <= r_sync1;
                r_level_d <= r_level;
                // Count consecutive samples that disagree with the accepted level.
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_pulse[i] = r_level & ~r_level_d;
    end

    logic w_ev_u;
    logic w_ev_c;
    logic w_ev_d;
    logic w_ev_l;
    logic w_ev_r;
    logic w_any_pulse;

    assign w_ev_u      = w_pulse[4];
    assign w_ev_c      = w_pulse[3] & ~w_pulse[4];
    assign w_ev_d      = w_pulse[2] & ~(|w_pulse[4:3]);
    assign w_ev_l      = w_pulse[1] & ~(|w_pulse[4:2]);
    assign w_ev_r      = w_pulse[0] & ~(|w_pulse[4:1]);
    assign w_any_pulse = |w_pulse;

    state_t               r_state;
    logic [1:0]           r_coin;
    logic [15:0]          r_amount;
    logic                 r_strobe;
    logic [c_ATT_W-1:0]   r_att;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [c_IDLE_W-1:0]  r_idle;

    logic               w_active;
    logic               w_dwell_state;
    logic               w_timeout;
    logic [c_ATT_W-1:0] w_att_next;

    assign w_active      = (r_state >= S_CARD) && (r_state <= S_CONFIRM);
    assign w_dwell_state = (r_state >= S_PROCESS) && (r_state <= S_GOODBYE);
    assign w_timeout     = w_active && !w_any_pulse && (r_idle == c_IDLE_LAST);
    assign w_att_next    = r_att + 1'b1;

    // Timers idle at zero outside their counting states, so entering a
    // counting state always starts from zero without an explicit clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_coin   <= 2'd0;
            r_amount <= 16'd0;
            r_strobe <= 1'b0;
            r_att    <= '0;
            r_dwell  <= '0;
            r_idle   <= '0;
        end else begin
            r_strobe <= 1'b0;
            r_idle   <= (w_active && !w_any_pulse) ? r_idle + 1'b1 : '0;
            r_dwell  <= w_dwell_state ? r_dwell + 1'b1 : '0;

            if (w_active && w_ev_u) begin
                r_state <= S_GOODBYE;
            end else if (w_timeout) begin
                r_state <= S_GOODBYE;
                r_idle  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_ev_c) r_state <= S_CARD;
                    S_CARD: if (w_ev_c) r_state <= S_PIN;
                    S_PIN: begin
                        if (w_ev_c) begin
                            if (SW == PIN_CODE) begin
                                r_state <= S_MENU;
                                r_att   <= '0;
                            end else begin
                                r_att <= w_att_next;
                                if (w_att_next == c_MAX_ATT) r_state <= S_LOCKED;
                            end
                        end
                    end
                    S_MENU: begin
                        if (w_ev_c)      r_state <= state_t'({2'b01, r_coin});
                        else if (w_ev_d) r_state <= S_GOODBYE;
                        else if (w_ev_l) r_coin  <= r_coin - 2'd1;
                        else if (w_ev_r) r_coin  <= r_coin + 2'd1;
                    end
                    S_VIEW_BTC, S_VIEW_ETH, S_VIEW_XRP, S_VIEW_LTC: begin
                        if (w_ev_c)      r_state <= S_AMOUNT;
                        else if (w_ev_d) r_state <= S_MENU;
                    end
                    S_AMOUNT: begin
                        if (w_ev_c) begin
                            r_amount <= SW;
                            if ((SW == 16'd0) || (SW > balance_in)) r_state <= S_INVALID;
                            else                                    r_state <= S_CONFIRM;
                        end else if (w_ev_d) begin
                            r_state <= S_MENU;
                        end
                    end
                    S_CONFIRM: begin
                        if (w_ev_c)      r_state <= S_PROCESS;
                        else if (w_ev_d) r_state <= S_MENU;
                    end
                    S_PROCESS: begin
                        if (r_dwell == c_PROC_LAST) begin
                            r_state  <= S_SUCCESS;
                            r_strobe <= 1'b1;
                            r_dwell  <= '0;
                        end
                    end
                    S_SUCCESS: begin
                        if (r_dwell == c_MSG_LAST) begin
                            r_state <= S_MENU;
                            r_dwell <= '0;
                        end
                    end
                    S_INVALID: begin
                        if (r_dwell == c_MSG_LAST) begin
                            r_state <= S_AMOUNT;
                            r_dwell <= '0;
                        end
                    end
                    S_LOCKED: begin
                        if (r_dwell == c_MSG_LAST) begin
                            r_state <= S_IDLE;
                            r_att   <= '0;
                            r_dwell <= '0;
                        end
                    end
                    S_GOODBYE: begin
                        if (r_dwell == c_MSG_LAST) begin
                            r_state  <= S_IDLE;
                            r_coin   <= 2'd0;
                            r_amount <= 16'd0;
                            r_att    <= '0;
                            r_dwell  <= '0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign state           = r_state;
    assign coin_sel        = r_coin;
    assign amount          = r_amount;
    assign withdraw_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_atm_control_fsm.sv
`default_nettype none
// Testbench for atm_control_fsm: scenario tasks with a session-level
// reference model (expected codes, coin index and dwell lengths).
module tb_atm_control_fsm;

    localparam int          DEB  = 4;
    localparam int          MSG  = 20;
    localparam int          PROC = 40;
    localparam int          TMO  = 60;
    localparam int          MAXT = 3;
    localparam logic [15:0] PIN  = 16'h1234;
    localparam int B_R = 0, B_L = 1, B_D = 2, B_C = 3, B_U = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  btn = 5'd0;
    logic [15:0] sw = 16'd0;
    logic [15:0] bal = 16'd0;
    logic [3:0]  state;
    logic [1:0]  coin_sel;
    logic [15:0] amount;
    logic        withdraw_strobe;

    int checks = 0;
    int errors = 0;
    int m_coin = 0;

    atm_control_fsm #(
        .DEBOUNCE_CYCLES(DEB),
        .PIN_CODE       (PIN),
        .MAX_TRIES      (MAXT),
        .MSG_CYCLES     (MSG),
        .PROC_CYCLES    (PROC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .BTNU           (btn[B_U]),
        .BTND           (btn[B_D]),
        .BTNL           (btn[B_L]),
        .BTNR           (btn[B_R]),
        .BTNC           (btn[B_C]),
        .SW             (sw),
        .balance_in     (bal),
        .state          (state),
        .coin_sel       (coin_sel),
        .amount         (amount),
        .withdraw_strobe(withdraw_strobe)
    );

    always #5 clk = ~clk;

    // Observer: how long each state lasted and when the strobe fired.
    int         cyc = 0;
    int         change_cyc = 0;
    int         last_dur = 0;
    int         strobe_cnt = 0;
    int         strobe_cyc = -1;
    logic [3:0] prev_state = 4'h0;
    logic [3:0] last_left = 4'h0;
    logic [3:0] strobe_state = 4'h0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (state !== prev_state) begin
            last_left  <= prev_state;
            last_dur   <= cyc - change_cyc;
            change_cyc <= cyc;
            prev_state <= state;
        end
        if (withdraw_strobe === 1'b1) begin
            strobe_cnt   <= strobe_cnt + 1;
            strobe_cyc   <= cyc;
            strobe_state <= state;
        end
    end

    task automatic press(input int b);
        @(negedge clk);
        btn[b] = 1'b1;
        repeat (8) @(negedge clk);
        btn[b] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_leave(input logic [3:0] st);
        int n;
        n = 0;
        while (state === st && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (state === st) begin
            checks++;
            errors++;
            $display("FAIL wait_leave: state stuck at %h", state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (state !== 4'h0) begin errors++; $display("FAIL reset_state: got %h exp 0", state); end
        checks++; if (coin_sel !== 2'd0 || amount !== 16'd0 || withdraw_strobe !== 1'b0) begin
            errors++; $display("FAIL reset_outs: coin=%0d amount=%0d strobe=%b exp 0/0/0", coin_sel, amount, withdraw_strobe);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_debounce();
        int n;
        @(negedge clk);
        btn[B_C] = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        btn[B_C] = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (state !== 4'h0) begin errors++; $display("FAIL short_press: state=%h exp 0", state); end
        @(negedge clk);
        btn[B_C] = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (state === 4'h1) break;
        end
        checks++; if (n != DEB + 3) begin errors++; $display("FAIL debounce_latency: got %0d cycles exp %0d", n, DEB + 3); end
        @(negedge clk);
        btn[B_C] = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (state !== 4'h1) begin errors++; $display("FAIL card_state: state=%h exp 1", state); end
    endtask

    task automatic test_pin_lockout();
        int att;
        int wrong;
        att = 0;
        press(B_C);
        checks++; if (state !== 4'h2) begin errors++; $display("FAIL pin_enter: state=%h exp 2", state); end
        sw = 16'h0000;
        for (int i = 0; i < MAXT; i++) begin
            press(B_C);
            att++;
            checks++; if (state !== ((att == MAXT) ? 4'hD : 4'h2)) begin
                errors++; $display("FAIL wrong_pin_%0d: state=%h exp %h", att, state, (att == MAXT) ? 4'hD : 4'h2);
            end
        end
        wait_leave(4'hD);
        checks++; if (last_left !== 4'hD || last_dur != MSG || state !== 4'h0) begin
            errors++; $display("FAIL locked_dwell: left=%h dur=%0d now=%h exp D/%0d/0", last_left, last_dur, state, MSG);
        end
        press(B_C);
        press(B_C);
        wrong = $urandom_range(0, MAXT - 1);
        for (int i = 0; i < wrong; i++) begin
            sw = PIN ^ 16'($urandom_range(1, 65535));
            press(B_C);
            checks++; if (state !== 4'h2) begin errors++; $display("FAIL retry_pin_%0d: state=%h exp 2", i, state); end
        end
        sw = PIN;
        press(B_C);
        checks++; if (state !== 4'h3) begin errors++; $display("FAIL good_pin: state=%h exp 3", state); end
    endtask

    task automatic test_menu();
        int b;
        press(B_L); m_coin = (m_coin + 3) % 4;
        checks++; if (coin_sel !== 2'(m_coin)) begin errors++; $display("FAIL coin_left: got %0d exp %0d", coin_sel, m_coin); end
        press(B_R); press(B_R); m_coin = (m_coin + 2) % 4;
        checks++; if (coin_sel !== 2'(m_coin)) begin errors++; $display("FAIL coin_right2: got %0d exp %0d", coin_sel, m_coin); end
        press(B_C);
        checks++; if (state !== 4'h4 + 4'(m_coin)) begin errors++; $display("FAIL coin_view: state=%h exp %h", state, 4'h4 + 4'(m_coin)); end
        press(B_D);
        checks++; if (state !== 4'h3) begin errors++; $display("FAIL view_back: state=%h exp 3", state); end
        for (int i = 0; i < 6; i++) begin
            b = ($urandom_range(0, 1) == 0) ? B_L : B_R;
            press(b);
            m_coin = (b == B_L) ? (m_coin + 3) % 4 : (m_coin + 1) % 4;
            checks++; if (coin_sel !== 2'(m_coin) || state !== 4'h3) begin
                errors++; $display("FAIL coin_walk_%0d: coin=%0d state=%h exp %0d/3", i, coin_sel, state, m_coin);
            end
        end
        press(B_C);
        press(B_C);
        checks++; if (state !== 4'h8) begin errors++; $display("FAIL amount_enter: state=%h exp 8", state); end
    endtask

    task automatic test_amount(output logic [15:0] ok_amt);
        bal = 16'($urandom_range(50, 1000));
        sw  = bal + 16'd1;
        press(B_C);
        checks++; if (state !== 4'hC || amount !== sw) begin
            errors++; $display("FAIL over_balance: state=%h amount=%0d exp C/%0d", state, amount, sw);
        end
        wait_leave(4'hC);
        checks++; if (last_dur != MSG || state !== 4'h8) begin
            errors++; $display("FAIL invalid_dwell: dur=%0d now=%h exp %0d/8", last_dur, state, MSG);
        end
        sw = 16'd0;
        press(B_C);
        checks++; if (state !== 4'hC) begin errors++; $display("FAIL zero_amount: state=%h exp C", state); end
        wait_leave(4'hC);
        checks++; if (state !== 4'h8) begin errors++; $display("FAIL zero_return: state=%h exp 8", state); end
        sw = bal;
        press(B_C);
        checks++; if (state !== 4'h9 || amount !== bal) begin
            errors++; $display("FAIL exact_balance: state=%h amount=%0d exp 9/%0d", state, amount, bal);
        end
        ok_amt = bal;
    endtask

    task automatic test_withdraw(input logic [15:0] exp_amt);
        int s0;
        s0 = strobe_cnt;
        press(B_C);
        checks++; if (state !== 4'hA || strobe_cnt != s0) begin
            errors++; $display("FAIL process_enter: state=%h strobes=%0d exp A/%0d", state, strobe_cnt, s0);
        end
        press(B_U);
        checks++; if (state !== 4'hA) begin errors++; $display("FAIL cancel_in_process: state=%h exp A", state); end
        wait_leave(4'hA);
        checks++; if (last_dur != PROC || state !== 4'hB) begin
            errors++; $display("FAIL process_dwell: dur=%0d now=%h exp %0d/B", last_dur, state, PROC);
        end
        checks++; if (strobe_cnt != s0 + 1 || strobe_state !== 4'hB || strobe_cyc != change_cyc || amount !== exp_amt) begin
            errors++; $display("FAIL strobe: count=%0d st=%h at=%0d chg=%0d amt=%0d exp %0d/B/same/%0d",
                               strobe_cnt - s0, strobe_state, strobe_cyc, change_cyc, amount, 1, exp_amt);
        end
        wait_leave(4'hB);
        checks++; if (last_dur != MSG || state !== 4'h3 || strobe_cnt != s0 + 1) begin
            errors++; $display("FAIL success_dwell: dur=%0d now=%h strobes=%0d exp %0d/3/1", last_dur, state, strobe_cnt - s0, MSG);
        end
    endtask

    task automatic test_timeout();
        press(B_C);
        press(B_C);
        checks++; if (state !== 4'h8) begin errors++; $display("FAIL to_amount: state=%h exp 8", state); end
        wait_leave(4'h8);
        checks++; if (last_dur != TMO || state !== 4'hE) begin
            errors++; $display("FAIL inactivity: dur=%0d now=%h exp %0d/E", last_dur, state, TMO);
        end
        wait_leave(4'hE);
        m_coin = 0;
        checks++; if (last_dur != MSG || state !== 4'h0 || coin_sel !== 2'd0 || amount !== 16'd0) begin
            errors++; $display("FAIL goodbye: dur=%0d st=%h coin=%0d amt=%0d exp %0d/0/0/0", last_dur, state, coin_sel, amount, MSG);
        end
    endtask

    task automatic test_cancel();
        press(B_U);
        checks++; if (state !== 4'h0) begin errors++; $display("FAIL cancel_idle: state=%h exp 0", state); end
        press(B_C);
        press(B_U);
        checks++; if (state !== 4'hE) begin errors++; $display("FAIL cancel_card: state=%h exp E", state); end
        wait_leave(4'hE);
        checks++; if (state !== 4'h0) begin errors++; $display("FAIL cancel_done: state=%h exp 0", state); end
    endtask

    task automatic test_reset_mid_dwell();
        press(B_C); press(B_C);
        sw = PIN; press(B_C);
        press(B_C); press(B_C);
        bal = 16'd500;
        sw  = 16'($urandom_range(1, 500));
        press(B_C); press(B_C);
        checks++; if (state !== 4'hA) begin errors++; $display("FAIL reach_process: state=%h exp A", state); end
        wait_leave(4'hA);
        repeat (5) @(negedge clk);
        checks++; if (state !== 4'hB || amount !== sw) begin
            errors++; $display("FAIL mid_success: state=%h amount=%0d exp B/%0d", state, amount, sw);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (state !== 4'h0 || coin_sel !== 2'd0 || amount !== 16'd0 || withdraw_strobe !== 1'b0) begin
            errors++; $display("FAIL mid_reset: st=%h coin=%0d amt=%0d strobe=%b exp 0/0/0/0", state, coin_sel, amount, withdraw_strobe);
        end
        reset = 1'b0;
        press(B_C);
        checks++; if (state !== 4'h1) begin errors++; $display("FAIL after_reset: state=%h exp 1", state); end
    endtask

    initial begin
        logic [15:0] ok_amt;
        test_reset();
        test_debounce();
        test_pin_lockout();
        test_menu();
        test_amount(ok_amt);
        test_withdraw(ok_amt);
        test_timeout();
        test_cancel();
        test_reset_mid_dwell();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
